// File: rtl/ifetch_queue.sv
// ifetch_queue: circular {pc, instr} FIFO between fetch and decode, emptied on flush.
// Optional zero-latency empty-queue bypass when IFETCH_QUEUE_BYPASS_EN is defined.
module ifetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [ILEN-1:0]          in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      rdPtr, wrPtr;
    logic [XLEN-1:0]  pcMem [DEPTH];
    logic [ILEN-1:0]  instrMem [DEPTH];
    logic             empty, full, push, pop, wrEn, rdEn;

    assign empty    = rdPtr == wrPtr;
    assign full     = (rdPtr[AW-1:0] == wrPtr[AW-1:0]) && (rdPtr[AW] != wrPtr[AW]);
    assign count    = wrPtr - rdPtr;
    assign in_ready = !full && !flush && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

`ifdef IFETCH_QUEUE_BYPASS_EN
    logic bypass;
    // An entry consumed straight through the bypass never touches storage.
    assign bypass    = empty && in_valid && !flush && !rst;
    assign out_valid = (!empty || bypass) && !flush;
    assign out_pc    = bypass ? in_pc : pcMem[rdPtr[AW-1:0]];
    assign out_instr = bypass ? in_instr : instrMem[rdPtr[AW-1:0]];
    assign wrEn      = push && !(bypass && out_ready);
    assign rdEn      = pop && !bypass;
`else
    assign out_valid = !empty && !flush;
    assign out_pc    = pcMem[rdPtr[AW-1:0]];
    assign out_instr = instrMem[rdPtr[AW-1:0]];
    assign wrEn      = push;
    assign rdEn      = pop;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcMem[i]    <= '0;
                instrMem[i] <= '0;
            end
        end else if (flush) begin
            rdPtr <= wrPtr;
        end else begin
            if (wrEn) begin
                pcMem[wrPtr[AW-1:0]]    <= in_pc;
                instrMem[wrPtr[AW-1:0]] <= in_instr;
                wrPtr                   <= wrPtr + 1'b1;
            end
            if (rdEn)
                rdPtr <= rdPtr + 1'b1;
        end
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch queue between the fetch stage and the decode stage.
- Buffers fetched {pc, instr} pairs in a small circular FIFO, so decode back-pressure does not throttle fetch immediately.
- Discards all buffered entries on a pipeline flush (branch/jump redirect) so no wrong-path instructions reach decode.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 32, width of PC value
ILEN, 32, width of encoded instruction

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents a valid {in_pc, in_instr}
in_ready  out  1  queue accepts an entry this cycle
in_pc  in  XLEN  PC of fetched instruction
in_instr  in  ILEN  fetched instruction encoding
flush  in  1  discard all entries (driven with the redirect-valid signal)
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode consumes head this cycle
out_pc  out  XLEN  PC of head entry
out_instr  out  ILEN  instruction of head entry
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage is DEPTH entries of {pc, instr}.
- rd_ptr and wr_ptr are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = !full && !flush && !rst.
  - in_ready does not depend on out_ready: no combinational path from decode to fetch.
- out_valid = !empty && !flush.
- out_pc / out_instr = storage[rd_ptr index]. Their value is don't-care when out_valid=0, but never X, because storage resets to 0.
- Latency: an entry pushed in cycle N appears on out_valid at cycle N+1 at the earliest.
- Push and pop in the same cycle:
  - Both pointers advance; count is unchanged.
  - Legal at any occupancy except full, because in_ready=0 when full.
- Full: in_ready=0. A pop in that cycle frees a slot, visible as in_ready=1 next cycle.
- Empty: out_valid=0. A push in that cycle is visible as out_valid=1 next cycle.
- Pointer wrap-around: index bits roll from DEPTH-1 to 0 and the wrap bit toggles. FIFO order is preserved across the wrap.
- Flush:
  - Highest priority. In a flush cycle both push and pop are suppressed, because in_ready and out_valid are both forced 0.
  - At the next edge rd_ptr <= wr_ptr, so the queue is empty and count=0 at cycle N+1.
  - Storage contents are not cleared.
  - An in_valid presented in the flush cycle is dropped. Fetch restarts from the redirect PC the following cycle.
- Reset:
  - At the next edge after rst=1: pointers <= 0, storage <= 0, count=0, out_valid=0, out_pc=0, out_instr=0.
  - While rst=1, in_ready=0.
  - Reset mid-operation drops all entries with no pop observed.
- Simultaneous rst and flush: reset wins; the result is identical.

Optional Feature:
- Macro: IFETCH_QUEUE_BYPASS_EN.
- Defined, when empty, !flush and in_valid:
  - out_valid=1 combinationally, with out_pc/out_instr = in_pc/in_instr (zero-latency bypass).
  - If out_ready is also 1, the entry is consumed directly and not written to storage; the pointers do not move.
  - If out_ready=0, the entry is pushed normally.
  - in_ready behaviour is unchanged.
- Undefined: minimum latency is 1 cycle, as in Behaviour, with no in-to-out combinational path.

Test Plan:
- Reset, then push pc=0x0/instr=0x00000013, out_ready=1 -> out_valid=1 one cycle later (same cycle with bypass) with out_pc=0x0, out_instr=0x00000013; count returns to 0.
- out_ready=0, push pcs 0x0,0x4,0x8,0xC (DEPTH=4) -> count=4, in_ready=0. Then raise out_ready -> pcs pop in order 0x0,0x4,0x8,0xC, and in_ready=1 the cycle after the first pop.
- Continuous push and pop with out_ready=1 for 10 instructions, pc 0x100..0x124 -> output sequence matches in order, pointers wrap twice, count stays <= 1, no bubbles after the first.
- Fill 3 entries, assert flush one cycle with in_valid=1 pc=0x200 -> in_ready=0 and out_valid=0 that cycle; count=0 next cycle; pc 0x200 never appears on the output.
- Full queue, out_ready=1 and in_valid=1 in the same cycle -> only the pop occurs (in_ready=0); count=3 next cycle, and the next push is accepted.
- Assert rst with 2 entries queued -> next cycle count=0, out_valid=0, out_pc=0; in_ready=1 after rst deasserts.
